// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues in-order fetch requests to instruction
// memory, buffers the returning words with their PCs, and hands them to the
// IF/ID register. A redirect flushes the queue and marks every request still
// in flight as stale so its response is thrown away when it arrives.
module ifetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   output logic [31:0] out_pc,
   output logic [31:0] out_inst,
   input  logic        out_ready
);

   localparam int unsigned AW        = $clog2(DEPTH);
   localparam int unsigned CW        = $clog2(DEPTH + 1);
   localparam logic [31:0] NOP_INST  = 32'h0000_0013;
   localparam logic [CW:0] DEPTH_SUM = (CW + 1)'(DEPTH);

   // Queue storage; only ever read through the occupancy-gated outputs,
   // so it needs no reset.
   logic [31:0]   entry_pc   [DEPTH];
   logic [31:0]   entry_inst [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;

   // Request/response bookkeeping. outstanding includes stale requests,
   // drop_cnt is how many of the oldest in-flight responses are stale.
   logic [CW-1:0] outstanding;
   logic [CW-1:0] drop_cnt;
   logic [31:0]   fetch_pc;
   logic [31:0]   rsp_pc;

   logic [CW:0]   in_flight;
   logic          req_fire;
   logic          rsp_accept;
   logic          rsp_keep;
   logic          rsp_drop;
   logic          pop;
   logic [CW-1:0] req_inc;
   logic [CW-1:0] rsp_dec;
   logic [CW-1:0] keep_inc;
   logic [CW-1:0] pop_dec;
   logic [31:0]   redirect_target;

   // Handshake decode, flow control and head-of-queue outputs.
   always_comb begin
      in_flight       = {1'b0, count} + {1'b0, outstanding};
      imem_req_valid  = !rst && !redirect && (in_flight < DEPTH_SUM);
      imem_req_addr   = fetch_pc;
      req_fire        = imem_req_valid && imem_req_ready;

      // A response with nothing outstanding is a protocol violation; it is
      // ignored so the counters never underflow.
      rsp_accept      = imem_rsp_valid && (outstanding != '0);
      rsp_keep        = rsp_accept && !redirect && (drop_cnt == '0);
      rsp_drop        = rsp_accept && !redirect && (drop_cnt != '0);

      out_valid       = (count != '0) && !redirect;
      pop             = out_valid && out_ready;
      out_pc          = (count != '0) ? entry_pc[rd_ptr]   : 32'h0000_0000;
      out_inst        = (count != '0) ? entry_inst[rd_ptr] : NOP_INST;

      req_inc         = CW'(req_fire);
      rsp_dec         = CW'(rsp_accept);
      keep_inc        = CW'(rsp_keep);
      pop_dec         = CW'(pop);
      redirect_target = redirect_pc & 32'hFFFF_FFFC;
   end

   // Fetch address and expected response PC, both restarted by a redirect.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         rsp_pc   <= RESET_PC;
      end else if (redirect) begin
         fetch_pc <= redirect_target;
         rsp_pc   <= redirect_target;
      end else begin
         if (req_fire) begin
            fetch_pc <= fetch_pc + 32'd4;
         end
         if (rsp_keep) begin
            rsp_pc <= rsp_pc + 32'd4;
         end
      end
   end

   // In-flight counter and stale-response counter; on redirect everything
   // still in flight (minus this cycle's response) becomes stale.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outstanding <= '0;
         drop_cnt    <= '0;
      end else if (redirect) begin
         outstanding <= outstanding - rsp_dec;
         drop_cnt    <= outstanding - rsp_dec;
      end else begin
         outstanding <= outstanding + req_inc - rsp_dec;
         if (rsp_drop) begin
            drop_cnt <= drop_cnt - CW'(1);
         end
      end
   end

   // Queue pointers and occupancy; a redirect empties the queue outright.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (redirect) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (rsp_keep) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + keep_inc - pop_dec;
      end
   end

   // Write kept responses at the tail; visible at the head one cycle later.
   always_ff @(posedge clk) begin
      if (rsp_keep) begin
         entry_pc[wr_ptr]   <= rsp_pc;
         entry_inst[wr_ptr] <= imem_rsp_data;
      end
   end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: a small in-order memory model answers
// accepted requests one cycle later, and each task drives one scenario and
// compares outputs against hand-derived values.
module tb_ifetch_queue;

   logic        clk;
   logic        rst;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic        out_ready;

   int tests_run;
   int tests_failed;

   bit          mem_enable;
   logic        smp_fire;
   logic [31:0] smp_addr;
   logic [31:0] pend_q [$];

   ifetch_queue #(
      .DEPTH    (4),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_pc         (out_pc),
      .out_inst       (out_inst),
      .out_ready      (out_ready)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Instruction memory contents as a function of address.
   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return {~addr[15:0], addr[15:0]} ^ 32'h1357_0000;
   endfunction

   // Sample the request handshake mid-cycle, where it is stable.
   initial begin
      smp_fire = 1'b0;
      smp_addr = '0;
      forever begin
         @(negedge clk);
         smp_fire = imem_req_valid && imem_req_ready;
         smp_addr = imem_req_addr;
      end
   end

   // In-order memory: answers each accepted request in the following cycle
   // unless held off by mem_enable; forgets everything while in reset.
   initial begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      forever begin
         @(posedge clk);
         #2;
         if (rst) begin
            pend_q.delete();
            imem_rsp_valid = 1'b0;
         end else begin
            if (smp_fire) begin
               pend_q.push_back(smp_addr);
            end
            if (mem_enable && pend_q.size() != 0) begin
               imem_rsp_valid = 1'b1;
               imem_rsp_data  = mem_word(pend_q.pop_front());
            end else begin
               imem_rsp_valid = 1'b0;
            end
         end
      end
   end

   // Advance to just after the next rising edge, where inputs are driven.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Bounded wait for out_valid, sampled at the falling edge.
   task automatic wait_out_valid(input int max_cycles, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max_cycles; i++) begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         next_cycle();
      end
   endtask

   // Hold reset for two edges and release it just after a rising edge.
   task automatic do_reset(input bit rdy, input bit ordy, input bit men);
      next_cycle();
      rst            = 1'b1;
      redirect       = 1'b0;
      redirect_pc    = '0;
      imem_req_ready = rdy;
      out_ready      = ordy;
      mem_enable     = men;
      next_cycle();
      next_cycle();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      tests_run++;
      if (imem_req_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_req_valid: got %b, expected 0", imem_req_valid);
      end
      tests_run++;
      if (out_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_out_valid: got %b, expected 0", out_valid);
      end
      tests_run++;
      if (out_pc !== 32'h0) begin
         tests_failed++;
         $display("[TB] FAIL reset_out_pc: got %h, expected 00000000", out_pc);
      end
      tests_run++;
      if (out_inst !== 32'h0000_0013) begin
         tests_failed++;
         $display("[TB] FAIL reset_out_inst: got %h, expected 00000013", out_inst);
      end
      next_cycle();
      @(negedge clk);
      tests_run++;
      if (imem_req_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_hold_req_valid: got %b, expected 0", imem_req_valid);
      end
      tests_run++;
      if (imem_req_addr !== 32'h0) begin
         tests_failed++;
         $display("[TB] FAIL reset_fetch_pc: got %h, expected 00000000", imem_req_addr);
      end
   endtask

   task automatic test_streaming();
      logic [31:0] exp_pc;
      do_reset(1'b1, 1'b1, 1'b1);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (k == 0) begin
            tests_run++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
               tests_failed++;
               $display("[TB] FAIL stream_first_req: got valid=%b addr=%h, expected valid=1 addr=00000000",
                        imem_req_valid, imem_req_addr);
            end
         end
         tests_run++;
         if (out_valid !== (k >= 2)) begin
            tests_failed++;
            $display("[TB] FAIL stream_valid%0d: got %b, expected %b", k, out_valid, (k >= 2));
         end
         if (k >= 2) begin
            exp_pc = 32'(4 * (k - 2));
            tests_run++;
            if (out_pc !== exp_pc || out_inst !== mem_word(exp_pc)) begin
               tests_failed++;
               $display("[TB] FAIL stream_head%0d: got pc=%h inst=%h, expected pc=%h inst=%h",
                        k, out_pc, out_inst, exp_pc, mem_word(exp_pc));
            end
         end
         next_cycle();
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_pc;
      do_reset(1'b1, 1'b0, 1'b1);
      repeat (9) next_cycle();
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b1 || imem_req_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL bp_full: got out_valid=%b req_valid=%b, expected out_valid=1 req_valid=0",
                  out_valid, imem_req_valid);
      end
      tests_run++;
      if (out_pc !== 32'h0 || out_inst !== mem_word(32'h0)) begin
         tests_failed++;
         $display("[TB] FAIL bp_head_stable: got pc=%h inst=%h, expected pc=00000000 inst=%h",
                  out_pc, out_inst, mem_word(32'h0));
      end
      next_cycle();
      imem_req_ready = 1'b0;
      out_ready      = 1'b1;
      for (int j = 0; j < 6; j++) begin
         @(negedge clk);
         tests_run++;
         if (out_valid !== (j < 4)) begin
            tests_failed++;
            $display("[TB] FAIL bp_drain_valid%0d: got %b, expected %b", j, out_valid, (j < 4));
         end
         if (j < 4) begin
            exp_pc = 32'(4 * j);
            tests_run++;
            if (out_pc !== exp_pc || out_inst !== mem_word(exp_pc)) begin
               tests_failed++;
               $display("[TB] FAIL bp_drain_pc%0d: got pc=%h inst=%h, expected pc=%h inst=%h",
                        j, out_pc, out_inst, exp_pc, mem_word(exp_pc));
            end
         end
         if (j == 1) begin
            tests_run++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10) begin
               tests_failed++;
               $display("[TB] FAIL bp_resume_req: got valid=%b addr=%h, expected valid=1 addr=00000010",
                        imem_req_valid, imem_req_addr);
            end
         end
         next_cycle();
      end
   endtask

   task automatic test_redirect_outstanding();
      logic [31:0] exp_pc;
      bit ok;
      do_reset(1'b1, 1'b1, 1'b0);
      repeat (3) next_cycle();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0103;
      @(negedge clk);
      tests_run++;
      if (imem_req_valid !== 1'b0 || out_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL redir_cycle: got req_valid=%b out_valid=%b, expected 0 0",
                  imem_req_valid, out_valid);
      end
      next_cycle();
      redirect   = 1'b0;
      mem_enable = 1'b1;
      @(negedge clk);
      tests_run++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
         tests_failed++;
         $display("[TB] FAIL redir_next_req: got valid=%b addr=%h, expected valid=1 addr=00000100",
                  imem_req_valid, imem_req_addr);
      end
      next_cycle();
      for (int s = 0; s < 3; s++) begin
         exp_pc = 32'h100 + 32'(4 * s);
         wait_out_valid(12, ok);
         tests_run++;
         if (!ok || out_pc !== exp_pc || out_inst !== mem_word(exp_pc)) begin
            tests_failed++;
            $display("[TB] FAIL redir_out%0d: got valid=%b pc=%h inst=%h, expected valid=1 pc=%h inst=%h",
                     s, ok, out_pc, out_inst, exp_pc, mem_word(exp_pc));
         end
         next_cycle();
      end
   endtask

   task automatic test_redirect_collision();
      logic [31:0] exp_pc;
      bit ok;
      do_reset(1'b1, 1'b1, 1'b1);
      repeat (5) next_cycle();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0200;
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL coll_no_pop: got out_valid=%b, expected 0", out_valid);
      end
      next_cycle();
      redirect = 1'b0;
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL coll_rsp_discarded: got out_valid=%b pc=%h, expected out_valid=0",
                  out_valid, out_pc);
      end
      tests_run++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
         tests_failed++;
         $display("[TB] FAIL coll_next_req: got valid=%b addr=%h, expected valid=1 addr=00000200",
                  imem_req_valid, imem_req_addr);
      end
      next_cycle();
      for (int s = 0; s < 2; s++) begin
         exp_pc = 32'h200 + 32'(4 * s);
         wait_out_valid(8, ok);
         tests_run++;
         if (!ok || out_pc !== exp_pc || out_inst !== mem_word(exp_pc)) begin
            tests_failed++;
            $display("[TB] FAIL coll_out%0d: got valid=%b pc=%h inst=%h, expected valid=1 pc=%h inst=%h",
                     s, ok, out_pc, out_inst, exp_pc, mem_word(exp_pc));
         end
         next_cycle();
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      do_reset(1'b1, 1'b1, 1'b0);
      repeat (2) next_cycle();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0300;
      next_cycle();
      redirect_pc = 32'h0000_0400;
      @(negedge clk);
      tests_run++;
      if (imem_req_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL b2b_req_blocked: got %b, expected 0", imem_req_valid);
      end
      next_cycle();
      redirect   = 1'b0;
      mem_enable = 1'b1;
      @(negedge clk);
      tests_run++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h400) begin
         tests_failed++;
         $display("[TB] FAIL b2b_next_req: got valid=%b addr=%h, expected valid=1 addr=00000400",
                  imem_req_valid, imem_req_addr);
      end
      next_cycle();
      wait_out_valid(12, ok);
      tests_run++;
      if (!ok || out_pc !== 32'h400 || out_inst !== mem_word(32'h400)) begin
         tests_failed++;
         $display("[TB] FAIL b2b_first_out: got valid=%b pc=%h inst=%h, expected valid=1 pc=00000400 inst=%h",
                  ok, out_pc, out_inst, mem_word(32'h400));
      end
      next_cycle();
   endtask

   task automatic test_wrap();
      logic [31:0] exp_pc;
      bit ok;
      do_reset(1'b1, 1'b1, 1'b1);
      repeat (3) next_cycle();
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFF8;
      next_cycle();
      redirect = 1'b0;
      for (int s = 0; s < 4; s++) begin
         exp_pc = 32'hFFFF_FFF8 + 32'(4 * s);
         wait_out_valid(10, ok);
         tests_run++;
         if (!ok || out_pc !== exp_pc || out_inst !== mem_word(exp_pc)) begin
            tests_failed++;
            $display("[TB] FAIL wrap_out%0d: got valid=%b pc=%h inst=%h, expected valid=1 pc=%h inst=%h",
                     s, ok, out_pc, out_inst, exp_pc, mem_word(exp_pc));
         end
         next_cycle();
      end
   endtask

   task automatic test_async_reset();
      bit ok;
      do_reset(1'b1, 1'b1, 1'b1);
      repeat (5) next_cycle();
      #2;
      rst = 1'b1;
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL async_valids: got out_valid=%b req_valid=%b, expected 0 0",
                  out_valid, imem_req_valid);
      end
      tests_run++;
      if (out_pc !== 32'h0 || out_inst !== 32'h0000_0013) begin
         tests_failed++;
         $display("[TB] FAIL async_outputs: got pc=%h inst=%h, expected pc=00000000 inst=00000013",
                  out_pc, out_inst);
      end
      next_cycle();
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      tests_run++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0 || out_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL async_restart: got req_valid=%b addr=%h out_valid=%b, expected 1 00000000 0",
                  imem_req_valid, imem_req_addr, out_valid);
      end
      next_cycle();
      wait_out_valid(8, ok);
      tests_run++;
      if (!ok || out_pc !== 32'h0 || out_inst !== mem_word(32'h0)) begin
         tests_failed++;
         $display("[TB] FAIL async_first_out: got valid=%b pc=%h inst=%h, expected valid=1 pc=00000000 inst=%h",
                  ok, out_pc, out_inst, mem_word(32'h0));
      end
      next_cycle();
   endtask

   // Guard against a hung run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   // Scenario sequence.
   initial begin
      tests_run      = 0;
      tests_failed   = 0;
      rst            = 1'b0;
      redirect       = 1'b0;
      redirect_pc    = '0;
      imem_req_ready = 1'b1;
      out_ready      = 1'b0;
      mem_enable     = 1'b0;
      #1;
      rst = 1'b1;
      test_reset();
      test_streaming();
      test_backpressure();
      test_redirect_outstanding();
      test_redirect_collision();
      test_back_to_back();
      test_wrap();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
